// File: rtl/vga_pkg.sv
// Shared VGA timing constants, crop-window geometry and the crop FSM state type.
// Pure definitions: no logic, no latency, no flow control.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int FB_AW    = 19;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    SEND,
    DONE
  } crop_state_e;

  // Crop window is centred on the active display area.
  function automatic int crop_left_x(input int width_len, input int lenet_size);
    return H_ACTIVE / 2 - (width_len * lenet_size) / 2;
  endfunction

  function automatic int crop_top_y(input int height_len, input int lenet_size);
    return V_ACTIVE / 2 - (height_len * lenet_size) / 2;
  endfunction

endpackage

// File: rtl/crop_addr_gen.sv
// Row/column sample counters with an incrementally built frame-buffer address.
// addr/last are registered; load takes priority over advance; no backpressure of its own.
module crop_addr_gen
  import vga_pkg::*;
#(
  parameter int N         = 28,
  parameter int ROW_BASE0 = 84480,
  parameter int COL0      = 212,
  parameter int ROW_STEP  = 5120,
  parameter int COL_STEP  = 8
) (
  input  logic             clk25,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  output logic [FB_AW-1:0] addr,
  output logic             last
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST_IDX = CW'(N - 1);
  localparam logic [FB_AW-1:0] RB0      = FB_AW'(ROW_BASE0);
  localparam logic [FB_AW-1:0] C0       = FB_AW'(COL0);
  localparam logic [FB_AW-1:0] RSTEP    = FB_AW'(ROW_STEP);
  localparam logic [FB_AW-1:0] CSTEP    = FB_AW'(COL_STEP);

  logic [CW-1:0]    row_q, row_d, col_q, col_d;
  logic [FB_AW-1:0] row_base_q, row_base_d, addr_q, addr_d;

  assign last = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign addr = addr_q;

  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    if (load) begin
      row_d      = '0;
      col_d      = '0;
      row_base_d = RB0;
      addr_d     = RB0 + C0;
    end else if (advance && !last) begin
      if (col_q == LAST_IDX) begin
        // Row wrap: restart the column walk from the next row base.
        col_d      = '0;
        row_d      = row_q + 1'b1;
        row_base_d = row_base_q + RSTEP;
        addr_d     = row_base_q + RSTEP + C0;
      end else begin
        col_d  = col_q + 1'b1;
        addr_d = addr_q + CSTEP;
      end
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      row_q      <= '0;
      col_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
    end
  end

endmodule

// File: rtl/lenet_crop_ctrl.sv
// Samples a centred LENET_SIZE^2 grid from the frame buffer and streams it out in raster order.
// 3 cycles per sample (issue, capture, send); holds the sample in SEND while out_ready is low.
module lenet_crop_ctrl
  import vga_pkg::*;
#(
  parameter int WIDTHLENGTH  = 8,
  parameter int HEIGHTLENGTH = 8,
  parameter int LENET_SIZE   = 28
) (
  input  logic             clk25,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sw,
  output logic [FB_AW-1:0] fb_addr,
  output logic             fb_rd_en,
  input  logic [3:0]       fb_pixel,
  output logic [3:0]       out_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int LEFT_X = crop_left_x(WIDTHLENGTH, LENET_SIZE);
  localparam int TOP_Y  = crop_top_y(HEIGHTLENGTH, LENET_SIZE);
  localparam int X0     = LEFT_X + WIDTHLENGTH / 2;
  localparam int Y0     = TOP_Y + HEIGHTLENGTH / 2;

  crop_state_e state_q, state_d;
  logic [3:0]  pix_q, pix_d;
  logic        gen_load, gen_adv, gen_last;

  crop_addr_gen #(
    .N        (LENET_SIZE),
    .ROW_BASE0(Y0 * H_ACTIVE),
    .COL0     (X0),
    .ROW_STEP (H_ACTIVE * HEIGHTLENGTH),
    .COL_STEP (WIDTHLENGTH)
  ) u_addr_gen (
    .clk25  (clk25),
    .rst_n  (rst_n),
    .load   (gen_load),
    .advance(gen_adv),
    .addr   (fb_addr),
    .last   (gen_last)
  );

  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    gen_load = 1'b0;
    gen_adv  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // sw only matters here, so dropping it mid-crop cannot abort a capture.
        if (start && sw) begin
          state_d  = ISSUE;
          gen_load = 1'b1;
        end
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        pix_d   = fb_pixel;
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (gen_last) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            gen_adv = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
    end
  end

  assign fb_rd_en  = (state_q == ISSUE);
  assign out_valid = (state_q == SEND);
  assign out_last  = (state_q == SEND) && gen_last;
  assign out_pixel = pix_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: doc/lenet_crop_ctrl.md
LENET_CROP_CTRL -- requirements
Module: lenet_crop_ctrl

Interface
REQ-001 Parameter WIDTHLENGTH, default 8, meaning horizontal display pixels per LeNet column.
REQ-002 Parameter HEIGHTLENGTH, default 8, meaning vertical display lines per LeNet row.
REQ-003 Parameter LENET_SIZE, default 28, meaning LeNet image edge in samples.
REQ-004 Port clk25  input  1  pixel clock, all logic on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port start  input  1  one-cycle request to capture one crop, normally the vsync leading edge.
REQ-007 Port sw  input  1  crop enable, the same switch that shows the green box.
REQ-008 Port fb_addr  output  19  frame-buffer read address, linear y*640+x.
REQ-009 Port fb_rd_en  output  1  frame-buffer read strobe.
REQ-010 Port fb_pixel  input  4  frame-buffer read data, valid exactly 1 cycle after fb_rd_en.
REQ-011 Port out_pixel  output  4  sample to the LeNet input stream.
REQ-012 Port out_valid  output  1  out_pixel valid.
REQ-013 Port out_ready  input  1  consumer accepts when out_valid and out_ready are both high.
REQ-014 Port out_last  output  1  marks sample (row 27, col 27).
REQ-015 Port busy  output  1  high in any state except IDLE.
REQ-016 Port done  output  1  one-cycle pulse after the last handshake.

Function
REQ-017 Crop window origin SHALL be LEFT_X = 640/2 - WIDTHLENGTH*LENET_SIZE/2 and TOP_Y = 480/2 - HEIGHTLENGTH*LENET_SIZE/2, which gives 208 and 128 at the defaults.
REQ-018 Sample (r,c) SHALL be read at x = LEFT_X + c*WIDTHLENGTH + WIDTHLENGTH/2 and y = TOP_Y + r*HEIGHTLENGTH + HEIGHTLENGTH/2.
REQ-019 Samples SHALL be emitted in raster order, c fastest, 784 samples per crop at the defaults.
REQ-020 Address SHALL be formed incrementally, without a multiplier: a row-base register advances by 640*HEIGHTLENGTH per row and a column offset advances by WIDTHLENGTH, all in 19 bits.
REQ-021 The FSM SHALL have the states IDLE, ISSUE, CAPTURE, SEND and DONE.
REQ-022 IDLE -> ISSUE SHALL occur when start=1 and sw=1; the counters and address load the (0,0) values in the same transition.
REQ-023 ISSUE SHALL assert fb_rd_en for exactly one cycle with fb_addr stable, then go to CAPTURE.
REQ-024 CAPTURE SHALL register fb_pixel into out_pixel, then go to SEND.
REQ-025 In SEND, out_valid=1 and out_pixel/out_last SHALL hold until out_ready=1. On handshake: go to ISSUE with the next address, or go to DONE if it was the last sample.
REQ-026 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 sw falling mid-crop SHALL NOT abort the crop; sw is sampled only in IDLE.
REQ-029 fb_rd_en SHALL be 0 in every state except ISSUE, and fb_addr SHALL hold its last value otherwise.
REQ-030 Per-sample cost SHALL be 3 cycles plus the ready stall, i.e. 2352 cycles minimum per crop, which fits in vertical blanking (36000 cycles).

Reset
REQ-031 rst_n=0 SHALL force, asynchronously and at any time including mid-crop: state IDLE, fb_addr=0, fb_rd_en=0, out_pixel=0, out_valid=0, out_last=0, busy=0, done=0, and the counters to 0.
REQ-032 After rst_n deasserts, no crop SHALL start until a new start pulse arrives.

Structure
REQ-033 The FSM state enum, the VGA timing constants (640, 480, 800, 525) and the LEFT_X/TOP_Y derivation SHALL live in shared package vga_pkg, which vga also imports.
REQ-034 The row and column counters plus the address accumulator SHALL form one sub-module, crop_addr_gen (inputs load, advance; outputs addr, last). The FSM stays in lenet_crop_ctrl.

Verification
REQ-035 Bench SHALL cover: defaults, start=1 with sw=1 and out_ready tied 1 -> first fb_addr=84692, second 84700, 29th (row 1) 89812, last 223148; exactly 784 out_valid handshakes; done pulses once, 2352+1 cycles after start.
REQ-036 Bench SHALL cover: fb model returning fb_pixel = addr[3:0] -> each out_pixel equals the low nibble of the corresponding address.
REQ-037 Bench SHALL cover: out_ready held 0 for 10 cycles on sample 5 -> out_valid, out_pixel and fb_addr stay stable, no fb_rd_en, and no sample is lost or duplicated.
REQ-038 Bench SHALL cover: start with sw=0 -> busy stays 0 and fb_rd_en never asserts. A second start at sample 100 -> ignored, total handshakes still 784.
REQ-039 Bench SHALL cover: rst_n pulsed low at sample 400 -> all outputs 0 within the same cycle and the FSM in IDLE. The next start restarts at address 84692.
REQ-040 Bench SHALL cover: out_last high only on the 784th sample, with done asserted the cycle after that handshake.
